dtc_share_sched: RTL and testbench
==================================

Name: dtc_share_sched

Overview:
- Time-multiplexes one 8-bit-in / 7-bit-out decision-tree classifier core between NREQ requesters.
- Round-robin arbitration grants one requester and latches its feature vector onto the core input. The input is held for CLS_LAT cycles.
- After that, the block captures the 7-bit class code and returns it tagged with the requester id over a valid/ready response port.
- It sits between the feature producers and the shared classifier instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- CLS_LAT, 1, cycles the core input must be held stable before cls_outp is sampled (1..8; 1 = purely combinational core)
- IDW, 2, width of requester id; must equal clog2(NREQ)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_data  in  NREQ*8  feature vectors; requester i on bits [8*i+7 : 8*i]
- cls_inp  out  8  driven to shared classifier core input
- cls_outp  in  7  class code from shared classifier core
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accept
- rsp_id  out  IDW  requester index of the result
- rsp_data  out  7  captured class code
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: rst=1 at a rising edge sets:
  - state=IDLE
  - rr_ptr=NREQ-1, so requester 0 has top priority first
  - cls_inp=0, rsp_valid=0, rsp_id=0, rsp_data=0
  - wait counter=0
- Reset mid-operation aborts any transaction without a response; no request is accepted in the reset cycle.
- States: IDLE, HOLD, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching (rr_ptr+1) mod NREQ upward with wrap.
  - req_ready is one-hot at g, combinational from req_valid, rr_ptr and state. req_ready=0 outside IDLE or when no valid.
  - On handshake (valid & ready) at cycle T:
    - cls_inp <= req_data[g]
    - id register <= g
    - rr_ptr <= g
    - counter <= CLS_LAT-1
    - state <= HOLD
- HOLD:
  - cls_inp is held constant.
  - If counter==0: rsp_data <= cls_outp, rsp_id <= id, rsp_valid <= 1, state <= RESP.
  - Else counter decrements.
  - Net timing: cls_outp is sampled at the end of cycle T+CLS_LAT, and rsp_valid is first high in cycle T+CLS_LAT+1.
- RESP:
  - rsp_valid, rsp_id and rsp_data stay stable until rsp_ready=1.
  - On handshake: rsp_valid <= 0, state <= IDLE.
  - No request is accepted in the RESP handshake cycle.
  - Maximum throughput is one result per CLS_LAT+2 cycles with rsp_ready tied high.
- cls_inp retains its last value in IDLE and RESP; it does not return to 0.
- The arbiter does not drop or reorder requests:
  - A requester with req_valid held high is granted within NREQ transactions.
  - A requester may deassert req_valid before it is granted without side effects.
- rr_ptr updates only on an accepted request; idle cycles do not move it.
- Fixed widths only, no arithmetic beyond the counter decrement and the modulo-NREQ wrap of the priority search.

Test Plan:
Bench stub for the core: cls_outp = cls_inp[6:0] ^ 7'h2A, combinational, CLS_LAT=1.
- Reset and single request:
  - Stimulus: rst for 2 cycles; req_valid=4'b0100, req_data[2]=8'h5B at cycle T; rsp_ready=1.
  - Required: req_ready=4'b0100 at T; cls_inp=8'h5B at T+1; rsp_valid=1, rsp_id=2, rsp_data=7'h71 at T+2; busy high T+1..T+2.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, data 8'h00/8'h11/8'h22/8'h33.
  - Required: grant order 0,1,2,3,0; rsp_id sequence matches; rsp_data = 7'h2A, 7'h3B, 7'h08, 7'h19.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises, then 1.
  - Required: rsp_valid/rsp_id/rsp_data stable all 5 cycles; req_ready=0 throughout; the next grant is no earlier than the cycle after the response handshake.
- Latency parameter:
  - Stimulus: CLS_LAT=4, stub registered through 3 stages, request at T.
  - Required: cls_inp constant T+1..T+4; rsp_valid first high at T+5 with the correct code.
- Reset mid-operation:
  - Stimulus: assert rst in the HOLD cycle.
  - Required: next cycle rsp_valid=0, busy=0, cls_inp=0; requester 0 wins the next contention with 4'b1111 valid.
- Withdrawn request:
  - Stimulus: req_valid[1] pulses high for 1 cycle while the block is in HOLD.
  - Required: requester 1 is never granted and no extra rsp_valid is produced.

Source files
------------

// File: rtl/dtc_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : dtc_share_sched
// Description : Shares one decision-tree classifier core between NREQ
//               requesters. A round-robin arbiter picks a requester, its
//               feature byte is held on the core input for CLS_LAT cycles,
//               and the class code is returned with the requester id over a
//               valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_share_sched #(
  parameter int NREQ    = 4,
  parameter int CLS_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_data,
  output logic [7:0]        cls_inp,
  input  logic [6:0]        cls_outp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [6:0]        rsp_data,
  output logic              busy
);

  localparam int C_CNTW = (CLS_LAT > 1) ? $clog2(CLS_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_id;
  logic [C_CNTW-1:0] r_cnt;
  logic [7:0]        r_cls_inp;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [6:0]        r_rsp_data;

  logic              w_found;
  logic [IDW-1:0]    w_gnt;
  logic [IDW:0]      w_idx;

  // Priority search starting one past the last grant, wrapping modulo NREQ;
  // the extra top bit of w_idx absorbs the carry before the wrap subtract.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end
    end
  end

  // One-hot accept toward the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found && !rst) begin
      req_ready = NREQ'(1) << w_gnt;
    end
  end

  // Control FSM: accept, hold the core input, capture, then present result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_cls_inp   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cls_inp <= req_data[8*w_gnt +: 8];
            r_id      <= w_gnt;
            r_rr_ptr  <= w_gnt;
            r_cnt     <= C_CNTW'(CLS_LAT - 1);
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= cls_outp;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - C_CNTW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cls_inp   = r_cls_inp;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dtc_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc_share_sched
// Description : Self-checking bench for dtc_share_sched (vector table,
//               directed corner sequences, randomized run against a model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc_share_sched;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic [7:0]  cls_inp;
  logic [6:0]  cls_outp;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [6:0]  rsp_data;

  logic [3:0]  req_valid2, req_ready2;
  logic [31:0] req_data2;
  logic [7:0]  cls_inp2;
  logic [6:0]  cls_outp2;
  logic        rsp_valid2, rsp_ready2, busy2;
  logic [1:0]  rsp_id2;
  logic [6:0]  rsp_data2;
  logic [6:0]  s1, s2, s3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dtc_share_sched #(.NREQ(4), .CLS_LAT(1), .IDW(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .cls_inp(cls_inp), .cls_outp(cls_outp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  dtc_share_sched #(.NREQ(4), .CLS_LAT(4), .IDW(2)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_data(req_data2), .cls_inp(cls_inp2), .cls_outp(cls_outp2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
    .rsp_data(rsp_data2), .busy(busy2)
  );

  // Classifier stubs: combinational for the main DUT, three register stages
  // for the long-latency instance.
  assign cls_outp = cls_inp[6:0] ^ 7'h2A;
  always @(posedge clk) begin
    s1 <= cls_inp2[6:0] ^ 7'h2A;
    s2 <= s1;
    s3 <= s2;
  end
  assign cls_outp2 = s3;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit         m_known = 0;
  int         m_ptr, m_id, m_age;
  bit         m_busy, m_rv;
  logic [7:0] m_cls;
  logic [6:0] m_dat;

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_check();
    int g;
    logic [3:0] er;
    if (!m_known) return;
    g  = pick(req_valid, m_ptr);
    er = (!m_busy && !rst && g >= 0) ? 4'(1 << g) : 4'b0000;
    check("m_req_ready", {28'b0, req_ready}, {28'b0, er});
    check("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rv});
    check("m_busy", {31'b0, busy}, {31'b0, m_busy});
    check("m_cls_inp", {24'b0, cls_inp}, {24'b0, m_cls});
    if (m_rv) begin
      check("m_rsp_id", {30'b0, rsp_id}, 32'(m_id));
      check("m_rsp_data", {25'b0, rsp_data}, {25'b0, m_dat});
    end
  endtask

  task automatic model_step();
    int g;
    if (rst) begin
      m_known = 1; m_ptr = NREQ - 1; m_busy = 0; m_rv = 0; m_cls = 8'h00; m_age = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_cls = req_data[8*g +: 8]; m_id = g; m_ptr = g; m_busy = 1; m_age = 0;
        end
      end else if (!m_rv) begin
        if (m_age == 0) begin   // CLS_LAT = 1: captured at end of first hold cycle
          m_rv = 1; m_dat = m_cls[6:0] ^ 7'h2A;
        end else m_age--;
      end else if (rsp_ready) begin
        m_rv = 0; m_busy = 0;
      end
    end
  endtask

  // Compare against the model, advance the model and the clock by one cycle.
  task automatic tick();
    #1;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; logic [3:0] v; logic [31:0] d; bit rr; bit chk; bit cid;
    logic [3:0] e_rdy; bit e_rv; logic [1:0] e_id; logic [6:0] e_dat;
    bit e_busy; logic [7:0] e_cls;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] v, input logic [31:0] d, input bit chk,
                     input bit cid, input logic [3:0] rdy, input bit rv, input logic [1:0] id,
                     input logic [6:0] dat, input bit bz, input logic [7:0] cls);
    vec_t e;
    e.rst = r; e.v = v; e.d = d; e.rr = 1'b1; e.chk = chk; e.cid = cid;
    e.e_rdy = rdy; e.e_rv = rv; e.e_id = id; e.e_dat = dat; e.e_busy = bz; e.e_cls = cls;
    tbl.push_back(e);
  endtask

  initial begin
    int rv_cnt;
    int bound;
    logic [1:0] hid;
    logic [6:0] hdat;

    rst = 1; req_valid = 0; req_data = 0; rsp_ready = 1;
    req_valid2 = 0; req_data2 = 0; rsp_ready2 = 1;

    // reset, then a single request from requester 2
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 7'h00, 0, 8'h00);
    add(1, 4'h0, 32'h0,        1, 1, 4'h0, 0, 0, 7'h00, 0, 8'h00);
    add(0, 4'h4, 32'h005B0000, 1, 0, 4'h4, 0, 0, 7'h00, 0, 8'h00);
    add(0, 4'h0, 32'h005B0000, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h5B);
    add(0, 4'h0, 32'h005B0000, 1, 1, 4'h0, 1, 2, 7'h71, 1, 8'h5B);
    add(0, 4'h0, 32'h005B0000, 1, 0, 4'h0, 0, 0, 7'h00, 0, 8'h5B);
    // reset again, then round-robin with all four requesting
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 7'h00, 0, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h1, 0, 0, 7'h00, 0, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 1, 4'h0, 1, 0, 7'h2A, 1, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h2, 0, 0, 7'h00, 0, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h11);
    add(0, 4'hF, 32'h33221100, 1, 1, 4'h0, 1, 1, 7'h3B, 1, 8'h11);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h4, 0, 0, 7'h00, 0, 8'h11);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h22);
    add(0, 4'hF, 32'h33221100, 1, 1, 4'h0, 1, 2, 7'h08, 1, 8'h22);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h8, 0, 0, 7'h00, 0, 8'h22);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h33);
    add(0, 4'hF, 32'h33221100, 1, 1, 4'h0, 1, 3, 7'h19, 1, 8'h33);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h1, 0, 0, 7'h00, 0, 8'h33);
    add(0, 4'hF, 32'h33221100, 1, 0, 4'h0, 0, 0, 7'h00, 1, 8'h00);
    add(0, 4'hF, 32'h33221100, 1, 1, 4'h0, 1, 0, 7'h2A, 1, 8'h00);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req_valid = tbl[i].v; req_data = tbl[i].d; rsp_ready = tbl[i].rr;
      #1;
      if (tbl[i].chk) begin
        check("t_req_ready", {28'b0, req_ready}, {28'b0, tbl[i].e_rdy});
        check("t_rsp_valid", {31'b0, rsp_valid}, {31'b0, tbl[i].e_rv});
        check("t_busy", {31'b0, busy}, {31'b0, tbl[i].e_busy});
        check("t_cls_inp", {24'b0, cls_inp}, {24'b0, tbl[i].e_cls});
        if (tbl[i].cid) begin
          check("t_rsp_id", {30'b0, rsp_id}, {30'b0, tbl[i].e_id});
          check("t_rsp_data", {25'b0, rsp_data}, {25'b0, tbl[i].e_dat});
        end
      end
      tick();
    end

    // response backpressure: requester 1 wins next (data 8'h22 -> 7'h08)
    req_valid = 4'hF; req_data = 32'h44332211; rsp_ready = 0;
    bound = 0;
    #1;
    while (!rsp_valid && bound < 8) begin
      tick(); bound++;
    end
    check("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
    hid = rsp_id; hdat = rsp_data;
    check("bp_id", {30'b0, hid}, 32'd1);
    check("bp_data", {25'b0, hdat}, 32'h08);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      check("bp_id_hold", {30'b0, rsp_id}, {30'b0, hid});
      check("bp_data_hold", {25'b0, rsp_data}, {25'b0, hdat});
      check("bp_no_ready", {28'b0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1;
    #1;
    check("bp_hs_no_ready", {28'b0, req_ready}, 32'd0);
    tick();
    check("bp_next_grant", {28'b0, req_ready}, 32'h4);
    tick();                                   // requester 2 accepted, now in HOLD

    // reset in the hold cycle
    rst = 1; req_valid = 4'h0;
    #1;
    check("mr_busy_before", {31'b0, busy}, 32'd1);
    tick();
    rst = 0; req_valid = 4'hF;
    #1;
    check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_cls_inp", {24'b0, cls_inp}, 32'd0);
    check("mr_grant0", {28'b0, req_ready}, 32'h1);
    tick();                                   // requester 0 accepted

    // withdrawn request from requester 1 during HOLD
    req_valid = 4'h2;
    rv_cnt = 0;
    #1;
    check("wd_busy", {31'b0, busy}, 32'd1);
    check("wd_no_ready_hold", {28'b0, req_ready}, 32'd0);
    tick();
    req_valid = 4'h0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rsp_valid) rv_cnt++;
      check("wd_never_grant1", {31'b0, req_ready[1]}, 32'd0);
      tick();
    end
    check("wd_rsp_count", 32'(rv_cnt), 32'd1);

    // long-latency instance: requester 3, data 8'hC5 -> 7'h6F
    req_valid2 = 4'h8; req_data2 = 32'hC5000000; rsp_ready2 = 1;
    #1;
    check("lat_ready", {28'b0, req_ready2}, 32'h8);
    tick();
    req_valid2 = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("lat_cls_hold", {24'b0, cls_inp2}, 32'hC5);
      check("lat_no_valid", {31'b0, rsp_valid2}, 32'd0);
      tick();
    end
    #1;
    check("lat_valid", {31'b0, rsp_valid2}, 32'd1);
    check("lat_id", {30'b0, rsp_id2}, 32'd3);
    check("lat_data", {25'b0, rsp_data2}, 32'h6F);
    tick();

    // randomized traffic checked against the model
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      rsp_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
